// File: rtl/tophat_cmd_rx.sv
// -----------------------------------------------------------------------------
// tophat_cmd_rx
//
// Input-capture stage in front of the tophat core. The command word and its
// strobe arrive on asynchronous pad inputs. Both are synchronised through
// matching flop chains. A rising edge on the synchronised strobe pushes the
// word, taken from the same chain position as the strobe, into a small
// show-ahead FIFO. The core drains the FIFO through a valid/ready port. A
// capture that finds the FIFO full is dropped and sets a sticky overflow flag.
//
// Ports:
//   clk       in   design clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   ena       in   design selected; captures are suppressed while low
//   strb_in   in   asynchronous capture strobe (ui_in[7])
//   data_in   in   asynchronous command word (ui_in[6:0])
//   m_valid   out  FIFO head valid
//   m_data    out  FIFO head word (show-ahead)
//   m_ready   in   consumer accepts the head this cycle
//   count     out  number of stored entries, 0..DEPTH
//   overflow  out  sticky drop flag
//   clr_ovf   in   synchronous clear of overflow
//
// Handshake: a word transfers on a rising clk edge where m_valid and m_ready
// are both 1. m_valid and m_data depend only on flops, never on m_ready, and
// m_ready is ignored while m_valid is 0. A word pushed into an empty FIFO is
// presented on the cycle after the write; there is no same-cycle bypass.
// -----------------------------------------------------------------------------
module tophat_cmd_rx #(
  parameter int DATA_W      = 7,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       strb_in,
  input  logic [DATA_W-1:0]          data_in,
  output logic                       m_valid,
  output logic [DATA_W-1:0]          m_data,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ---------------------------------------------------------------------------
  // Synchronisers. Strobe and data shift in lockstep so the word written is
  // the one that sat on the pads when the strobe was first sampled high.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] strb_sync;
  logic [DATA_W-1:0]      data_sync [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        data_sync[i] <= '0;
      end
    end else begin
      strb_sync <= {strb_sync[SYNC_STAGES-2:0], strb_in};
      data_sync[0] <= data_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        data_sync[i] <= data_sync[i-1];
      end
    end
  end

  logic              strb_synced;
  logic [DATA_W-1:0] data_synced;

  assign strb_synced = strb_sync[SYNC_STAGES-1];
  assign data_synced = data_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Edge detect. The history flop tracks the synced strobe every cycle, even
  // with ena low, so an edge that arrives while deselected is consumed and
  // cannot be replayed when ena returns.
  // ---------------------------------------------------------------------------
  logic strb_hist;
  logic push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_hist <= 1'b0;
    end else begin
      strb_hist <= strb_synced;
    end
  end

  assign push = strb_synced & ~strb_hist & ena;

  // ---------------------------------------------------------------------------
  // FIFO storage and control.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;

  logic full;
  logic pop;
  logic wr_en;
  logic drop;

  assign full = (count_q == CNT_W'(DEPTH));
  assign pop  = m_valid & m_ready;
  // A pop in the same cycle frees the slot the push needs, so a full FIFO
  // still accepts the word when the head is leaving.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= data_synced;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Set has priority over clear so a drop is never hidden by a clear
  // landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (clr_ovf) begin
      overflow_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all derived from flops only.
  // ---------------------------------------------------------------------------
  assign m_valid  = (count_q != '0);
  assign m_data   = mem[rd_ptr];
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_tophat_cmd_rx.sv
`timescale 1ns/1ps
module tb_tophat_cmd_rx;

  localparam int DATA_W = 7;
  localparam int DEPTH  = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic              strb_in;
  logic [DATA_W-1:0] data_in;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
  logic [2:0]        count;
  logic              overflow;
  logic              clr_ovf;

  always #5 clk = ~clk;

  tophat_cmd_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .strb_in  (strb_in),
    .data_in  (data_in),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks. Inputs change 1ns after the rising edge; outputs are checked
  // at that same point, well away from the next edge.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Strobe rise sampled at edge N, written at edge N+2, then the strobe is
  // lowered and allowed to flush through the chain and history flop.
  task automatic capture(input logic [DATA_W-1:0] d);
    data_in = d;
    strb_in = 1'b1;
    repeat (3) step();
    strb_in = 1'b0;
    repeat (3) step();
  endtask

  logic [DATA_W-1:0] exp_word;
  logic              model_pop;
  logic              model_push;
  logic              model_full;

  initial begin
    rst_n   = 1'b0;
    ena     = 1'b1;
    strb_in = 1'b0;
    data_in = '0;
    m_ready = 1'b0;
    clr_ovf = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();

    // Single capture with two-edge latency, held strobe does not retrigger
    data_in = 7'h2A;
    strb_in = 1'b1;
    step();
    chk("cap_lat_n", 32'(m_valid), 32'd0);
    step();
    chk("cap_lat_n1", 32'(m_valid), 32'd0);
    step();
    chk("cap_valid_n2", 32'(m_valid), 32'd1);
    chk("cap_data_n2", 32'(m_data), 32'h2A);
    chk("cap_count_n2", 32'(count), 32'd1);
    repeat (20) step();
    chk("hold_count", 32'(count), 32'd1);
    strb_in = 1'b0;
    repeat (3) step();
    m_ready = 1'b1;
    chk("hold_valid_before_pop", 32'(m_valid), 32'd1);
    step();
    chk("pop_valid", 32'(m_valid), 32'd0);
    chk("pop_count", 32'(count), 32'd0);

    // Push into empty FIFO with m_ready already high: no bypass
    data_in = 7'h15;
    strb_in = 1'b1;
    repeat (3) step();
    chk("nobyp_valid", 32'(m_valid), 32'd1);
    chk("nobyp_count", 32'(count), 32'd1);
    chk("nobyp_data", 32'(m_data), 32'h15);
    step();
    chk("nobyp_popped_valid", 32'(m_valid), 32'd0);
    chk("nobyp_popped_count", 32'(count), 32'd0);
    strb_in = 1'b0;
    m_ready = 1'b0;
    repeat (3) step();

    // Fill and drain
    for (int i = 1; i <= 4; i++) capture(7'(i));
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_overflow", 32'(overflow), 32'd0);
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_valid", 32'(m_valid), 32'd1);
      chk("drain_data", 32'(m_data), 32'(i));
      step();
    end
    chk("drain_end_valid", 32'(m_valid), 32'd0);
    chk("drain_end_count", 32'(count), 32'd0);
    m_ready = 1'b0;

    // Overflow while full
    for (int i = 1; i <= 4; i++) capture(7'(i));
    capture(7'h55);
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(m_data), 32'h01);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Clear coincides with a drop: set wins
    data_in = 7'h56;
    strb_in = 1'b1;
    repeat (2) step();
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    chk("ovf_set_wins_count", 32'(count), 32'd4);
    strb_in = 1'b0;
    repeat (3) step();

    // Push with pop while full: accepted, 0x7F lands at the tail
    data_in = 7'h7F;
    strb_in = 1'b1;
    repeat (2) step();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("fullpp_count", 32'(count), 32'd4);
    chk("fullpp_head", 32'(m_data), 32'h02);
    strb_in = 1'b0;
    repeat (3) step();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: exp_word = 7'h02;
        1: exp_word = 7'h03;
        2: exp_word = 7'h04;
        default: exp_word = 7'h7F;
      endcase
      chk("fullpp_drain_valid", 32'(m_valid), 32'd1);
      chk("fullpp_drain_data", 32'(m_data), 32'(exp_word));
      step();
    end
    chk("fullpp_empty", 32'(m_valid), 32'd0);
    m_ready = 1'b0;
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;

    // Wrap-around with random m_ready against a queue model
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      for (int ph = 0; ph < 6; ph++) begin
        if (ph == 0) begin
          data_in = 7'(8'h10 + i * 7);
          strb_in = 1'b1;
        end
        if (ph == 3) strb_in = 1'b0;
        m_ready = 1'($urandom_range(0, 1));
        chk("wrap_count", 32'(count), 32'(exp_q.size()));
        chk("wrap_valid", 32'(m_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk("wrap_data", 32'(m_data), 32'(exp_q[0]));
        model_pop  = (exp_q.size() != 0) && m_ready;
        model_full = (exp_q.size() == DEPTH);
        model_push = (ph == 2);
        step();
        if (model_pop) void'(exp_q.pop_front());
        if (model_push && (!model_full || model_pop)) exp_q.push_back(7'(8'h10 + i * 7));
      end
    end
    m_ready = 1'b1;
    for (int k = 0; k < 8 && exp_q.size() != 0; k++) begin
      chk("wrap_drain_data", 32'(m_data), 32'(exp_q[0]));
      step();
      void'(exp_q.pop_front());
    end
    chk("wrap_model_empty", 32'(exp_q.size()), 32'd0);
    chk("wrap_dut_empty", 32'(m_valid), 32'd0);
    chk("wrap_no_ovf", 32'(overflow), 32'd0);
    m_ready = 1'b0;

    // Edge while ena=0 is lost, even after ena returns
    ena = 1'b0;
    data_in = 7'h11;
    strb_in = 1'b1;
    repeat (3) step();
    chk("ena_off_count", 32'(count), 32'd0);
    ena = 1'b1;
    repeat (3) step();
    chk("ena_back_count", 32'(count), 32'd0);
    chk("ena_back_valid", 32'(m_valid), 32'd0);
    strb_in = 1'b0;
    repeat (3) step();

    // Asynchronous reset mid-operation with count=3 and overflow set
    for (int i = 0; i < 4; i++) capture(7'(8'h21 + i));
    capture(7'h25);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_ovf", 32'(overflow), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(m_valid), 32'd0);
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_ovf", 32'(overflow), 32'd0);
    chk("async_rst_data", 32'(m_data), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (2) step();
    capture(7'h3C);
    chk("post_rst_valid", 32'(m_valid), 32'd1);
    chk("post_rst_data", 32'(m_data), 32'h3C);
    chk("post_rst_count", 32'(count), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
